booth_r4_mult_seq: RTL and testbench
====================================

Name: booth_r4_mult_seq

Overview:
- Parametrised sequential radix-4 (modified) Booth multiplier: recode control, iteration counter and datapath in one block.
- Successor to the fixed 16-step Booth controller. Generalised to WIDTH bits, with signed/unsigned mode, a start/ready/done handshake and a held result.
- Sits in the multdiv unit. The ALU issues operands; the pipeline stalls on busy and latches product on done.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- CW, $clog2(WIDTH/2+2), width of iteration counter / iter_cnt port.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when ready=1.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- mcand  in  WIDTH  multiplicand; sampled with start.
- mplier  in  WIDTH  multiplier; sampled with start.
- ready  out  1  block can accept start (states IDLE and DONE).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; product valid.
- product  out  2*WIDTH  result; held until next accepted start.
- iter_cnt  out  CW  RUN iterations executed for the current/last operation.

Behaviour:
- Reset (clr_n low, async, any state including mid-RUN): state=IDLE, product=0, done=0, busy=0, ready=1, iter_cnt=0. Partial result is discarded and no done is issued.
- States: IDLE -> RUN on accepted start; RUN -> DONE after N iterations; DONE -> IDLE after one cycle, or DONE -> RUN if start is high in DONE (back-to-back).
- start while busy=1 is ignored. Operand registers, mode and count are unaffected.
- Capture on accept:
  - acc=0, iter_cnt=0, lookback bit=0.
  - M = mcand extended to 2*WIDTH: sign-extended if signed_mode, else zero-extended.
  - Q = mplier extended to WIDTH+2 bits by the same rule.
  - N = WIDTH/2 if signed, WIDTH/2+1 if unsigned.
- Each RUN cycle:
  - triple = {Q[1],Q[0],lookback}.
  - Digit: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - acc += digit*M, modulo 2^(2*WIDTH).
  - Then M <<= 2; lookback = Q[1]; Q >>= 2 arithmetic (sign preserved); iter_cnt++.
- done is high for exactly the DONE cycle. product = acc, valid from DONE onward and held through IDLE.
- Latency: done is asserted N+1 clocks after the accepting edge.
  - WIDTH=32: 17 clocks signed, 18 clocks unsigned.
- Result is the exact 2*WIDTH-bit product; no overflow is possible.
- Boundary: iter_cnt saturates at N; the counter never wraps.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined:
  - At the start of each RUN cycle, if all bits of Q and lookback are equal (all 0 or all 1), every remaining digit is 0.
  - The block skips the add and goes directly to DONE. iter_cnt keeps the count of adds actually performed.
  - For mplier=0 or a signed mplier of -1 after its last nonzero digit, done comes early: minimum 2 clocks after accept.
- Undefined: always exactly N RUN cycles. The result is identical in both builds.

Test Plan:
- WIDTH=8, signed, mcand=0xFD (-3), mplier=0x07 -> product=0xFFEB, done 5 clocks after accept, iter_cnt=4 (macro off).
- WIDTH=8, unsigned, mcand=0xFF, mplier=0xFF -> product=0xFE01, done 6 clocks after accept, iter_cnt=5.
- WIDTH=8, signed, 0x80*0x80 -> product=0x4000; unsigned 0x80*0x80 -> 0x4000; signed 0x80*0x7F -> 0xC080.
- mplier=0x00, WIDTH=8, signed: macro on -> done 2 clocks after accept, iter_cnt=0, product=0; macro off -> done at 5 clocks.
- clr_n pulsed low during the 2nd RUN cycle -> product=0, busy=0, ready=1 immediately (async), no done pulse. A new start then completes normally.
- start held high through RUN with different operands -> ignored. start in DONE with 3*5 signed -> second done 5 clocks later, product=0x000F, first product seen on first done.

Source files
------------

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 (modified) Booth multiplier with start/ready/done handshake and held product.
// Optional: define BOOTH_EARLY_TERM_EN to finish as soon as every remaining Booth digit is zero.
module booth_r4_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH/2+2)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [CW-1:0]      iter_cnt
);
    localparam int PW = 2*WIDTH;
    localparam int QW = WIDTH+2;
    localparam logic [CW-1:0] N_SIGNED   = CW'(WIDTH/2);
    localparam logic [CW-1:0] N_UNSIGNED = CW'(WIDTH/2+1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    state_e               state_q, state_d;
    logic signed [PW-1:0] acc_q, acc_d;
    logic signed [PW-1:0] m_q, m_d;
    logic signed [QW-1:0] q_q, q_d;
    logic                 lb_q, lb_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        n_q, n_d;
    logic                 accept;
    logic                 skip;

    function automatic logic signed [PW-1:0] booth_addend(input logic [2:0] triple,
                                                          input logic signed [PW-1:0] m);
        booth_addend = '0;
        case (triple)
            3'b001, 3'b010: booth_addend = m;
            3'b011:         booth_addend = m <<< 1;
            3'b100:         booth_addend = -(m <<< 1);
            3'b101, 3'b110: booth_addend = -m;
            default:        booth_addend = '0;
        endcase
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] lim);
        sat_inc = (v >= lim) ? v : v + CW'(1);
    endfunction

    assign accept = start && (state_q != RUN);

`ifdef BOOTH_EARLY_TERM_EN
    // Q and lookback all-equal means every remaining recoded digit is zero.
    assign skip = (&{q_q, lb_q}) || !(|{q_q, lb_q});
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        lb_d    = lb_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    lb_d    = 1'b0;
                    m_d     = {{WIDTH{signed_mode & mcand[WIDTH-1]}}, mcand};
                    q_d     = {{2{signed_mode & mplier[WIDTH-1]}}, mplier};
                    n_d     = signed_mode ? N_SIGNED : N_UNSIGNED;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (skip) begin
                    state_d = DONE;
                end else begin
                    acc_d = acc_q + booth_addend({q_q[1:0], lb_q}, m_q);
                    m_d   = m_q <<< 2;
                    lb_d  = q_q[1];
                    q_d   = q_q >>> 2;
                    cnt_d = sat_inc(cnt_q, n_q);
                    if (cnt_d == n_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand shift registers need no reset: they are always loaded on accept.
    always_ff @(posedge clk) begin
        m_q  <= m_d;
        q_q  <= q_d;
        lb_q <= lb_d;
        n_q  <= n_d;
    end

    assign ready    = (state_q == IDLE) || (state_q == DONE);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign product  = acc_q;
    assign iter_cnt = cnt_q;
endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// Scoreboard bench for booth_r4_mult_seq at WIDTH=8 with hand-computed products, counts and latencies.
module tb_booth_r4_mult_seq;
    localparam int W  = 8;
    localparam int CW = $clog2(W/2+2);
`ifdef BOOTH_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           clr_n = 1'b0;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [CW-1:0]  iter_cnt;

    typedef struct {
        logic [2*W-1:0] p;
        int             cnt;
        int             cyc;
        string          name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    booth_r4_mult_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .signed_mode(signed_mode),
        .mcand      (mcand),
        .mplier     (mplier),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .iter_cnt   (iter_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (clr_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_product"}, product, mon_e.p);
                check({mon_e.name, "_iter_cnt"}, iter_cnt, mon_e.cnt);
                check({mon_e.name, "_done_cycle"}, cyc, mon_e.cyc);
                check({mon_e.name, "_busy_in_done"}, busy, 0);
            end
        end
    end

    task automatic push_exp(input string name, input logic [2*W-1:0] p,
                            input int lat_off, input int cnt_off, input int lat_on, input int cnt_on);
        exp_t e;
        e.p    = p;
        e.cnt  = ET ? cnt_on : cnt_off;
        e.cyc  = cyc + (ET ? lat_on : lat_off);
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_ready_timeout: ready=%b, expected 1", name, ready);
        end
    endtask

    task automatic run(input string name, input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] p, input int lat_off, input int cnt_off,
                       input int lat_on, input int cnt_on);
        signed_mode = sm;
        mcand       = a;
        mplier      = b;
        start       = 1'b1;
        push_exp(name, p, lat_off, cnt_off, lat_on, cnt_on);
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_busy"}, busy, 1);
        wait_ready(name);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        check({name, "_held"}, product, p);
        check({name, "_idle_ready"}, ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        check("reset_iter_cnt", iter_cnt, 0);
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        @(posedge clk); #1;

        //   name        sm  mcand  mplier product  lat/cnt off  lat/cnt on
        run("s_m3x7",    1, 8'hFD, 8'h07, 16'hFFEB, 5, 4, 4, 2);
        run("u_ffxff",   0, 8'hFF, 8'hFF, 16'hFE01, 6, 5, 6, 5);
        run("s_80x80",   1, 8'h80, 8'h80, 16'h4000, 5, 4, 5, 4);
        run("u_80x80",   0, 8'h80, 8'h80, 16'h4000, 6, 5, 6, 5);
        run("s_80x7f",   1, 8'h80, 8'h7F, 16'hC080, 5, 4, 5, 4);
        run("s_55x00",   1, 8'h55, 8'h00, 16'h0000, 5, 4, 2, 0);
        run("s_05xff",   1, 8'h05, 8'hFF, 16'hFFFB, 5, 4, 3, 1);

        // Asynchronous clear in the second RUN cycle discards the operation.
        signed_mode = 1'b1; mcand = 8'hFD; mplier = 8'h07; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrun_iter_cnt", iter_cnt, 1);
        check("midrun_busy", busy, 1);
        #2 clr_n = 1'b0;
        #1;
        check("clr_product", product, 0);
        check("clr_busy", busy, 0);
        check("clr_ready", ready, 1);
        check("clr_done", done, 0);
        check("clr_iter_cnt", iter_cnt, 0);
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("after_clr_product", product, 0);
        run("u_12x34",   0, 8'h12, 8'h34, 16'h03A8, 6, 5, 6, 4);

        // start held through RUN with changing operands, then back-to-back issue from DONE.
        signed_mode = 1'b1; mcand = 8'hFD; mplier = 8'h07; start = 1'b1;
        push_exp("b2b_first", 16'hFFEB, 5, 4, 4, 2);
        @(posedge clk); #1;
        signed_mode = 1'b0; mcand = 8'h11; mplier = 8'h22;
        @(posedge clk); #1;
        mcand = 8'h7E; mplier = 8'h81;
        wait_ready("b2b_first");
        check("b2b_first_done_state", done, 1);
        signed_mode = 1'b1; mcand = 8'h03; mplier = 8'h05;
        push_exp("b2b_second", 16'h000F, 5, 4, 4, 2);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_second_busy", busy, 1);
        wait_ready("b2b_second");
        @(posedge clk); #1;
        check("b2b_second_held", product, 16'h000F);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
